// File: rtl/bar_sort_engine.sv
// rtl/bar_sort_engine.sv - step-paced bubble sort over N_BARS bar heights
module bar_sort_engine #(
  parameter int N_BARS   = 5,
  parameter int HEIGHT_W = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [2:0]                 load_idx,
  input  logic [HEIGHT_W-1:0]        load_height,
  input  logic                       start,
  input  logic                       step,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 cmp_idx,
  output logic                       swapped,
  output logic [2:0]                 pass_count,
  output logic [7:0]                 swap_count,
  output logic [N_BARS*HEIGHT_W-1:0] heights_flat
);

  typedef enum logic [1:0] {IDLE, COMPARE, SWAP, DONE} state_t;

  state_t              state;
  logic [HEIGHT_W-1:0] h [N_BARS];
  logic [2:0]          j;
  logic [2:0]          j_next;
  logic                pass_swapped;
  logic                load_ok;
  logic                greater;
  logic                at_pass_end;
  logic                last_pass;
  logic                flag_now;

  always_comb begin
    j_next      = j + 3'd1;
    load_ok     = int'(load_idx) < N_BARS;
    greater     = h[j] > h[j_next];
    at_pass_end = int'(j) >= N_BARS - 2 - int'(pass_count);
    last_pass   = int'(pass_count) >= N_BARS - 2;
    // a swap happening this cycle counts toward the pass even before the flag register updates
    flag_now    = pass_swapped || (state == SWAP);
  end

  assign cmp_idx = j;

  for (genvar g = 0; g < N_BARS; g++) begin : g_flat
    assign heights_flat[g*HEIGHT_W +: HEIGHT_W] = h[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      swapped      <= 1'b0;
      j            <= 3'd0;
      pass_count   <= 3'd0;
      swap_count   <= 8'd0;
      pass_swapped <= 1'b0;
      for (int i = 0; i < N_BARS; i++) begin
        h[i] <= HEIGHT_W'((N_BARS - i) * 10);
      end
    end else begin
      swapped <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load_en) begin
            if (load_ok) begin
              h[load_idx] <= load_height;
              done        <= 1'b0;
              state       <= IDLE;
            end
          end else if (start) begin
            j            <= 3'd0;
            pass_count   <= 3'd0;
            swap_count   <= 8'd0;
            pass_swapped <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            state        <= COMPARE;
          end
        end
        COMPARE, SWAP: begin
          if (state == SWAP) begin
            h[j]         <= h[j_next];
            h[j_next]    <= h[j];
            swapped      <= 1'b1;
            pass_swapped <= 1'b1;
            if (swap_count != 8'hFF) swap_count <= swap_count + 8'd1;
          end
          if (state == COMPARE && step && greater) begin
            state <= SWAP;
          end else if (state == SWAP || step) begin
            if (!at_pass_end) begin
              j     <= j_next;
              state <= COMPARE;
            end else if (!flag_now || last_pass) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pass_count   <= pass_count + 3'd1;
              j            <= 3'd0;
              pass_swapped <= 1'b0;
              state        <= COMPARE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
